// File: rtl/sp_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sp_ram_pkg
// Purpose  : Shared state encoding and depth helper for the single-port RAM
//            controller.
// Revision : 1.0 - initial release
// ============================================================================
package sp_ram_pkg;

    // Controller operating mode: serving requests or filling memory.
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Number of words addressed by an aw-bit address.
    function automatic int unsigned depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sp_ram.sv
`default_nettype none
// ============================================================================
// Module   : sp_ram
// Purpose  : Single-port RAM, 1-cycle registered read. douta only updates on
//            read accesses, so writes leave the last read word visible.
// Revision : 1.0 - initial release
// ============================================================================
module sp_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clka,
    input  logic                  ena,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    output logic [DATA_WIDTH-1:0] douta
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    // Write on enabled write cycles, register read data on enabled reads.
    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) begin
                r_mem[addra] <= dina;
            end else begin
                douta <= r_mem[addra];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sync_fifo2.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo2
// Purpose  : Two-entry synchronous FIFO with push/pop and occupancy count.
//            Head is valid whenever count is non-zero. The caller never
//            pushes when full or pops when empty.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;

    // Storage is data-only and needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wptr] <= push_data;
        end
    end

    // Pointers and count; simultaneous push and pop keep the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (push) begin
                r_wptr <= ~r_wptr;
            end
            if (pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rptr];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/sp_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sp_ram_ctrl
// Purpose  : Initiator-side controller for sp_ram. Converts valid/ready
//            requests into single RAM accesses, returns read data in order
//            through a 2-entry buffer, and runs a sequential clear engine.
// Revision : 1.0 - initial release
// ============================================================================
module sp_ram_ctrl
    import sp_ram_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    ADDR_WIDTH    = 10,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0,
    parameter bit                    INIT_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    input  logic                  clear_start,
    output logic                  clear_busy,
    output logic                  clear_done,
    output logic                  ram_ena,
    output logic                  ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dina,
    input  logic [DATA_WIDTH-1:0] ram_douta
);

    // Extra counter bit so the last address compares without wrapping to 0.
    localparam logic [ADDR_WIDTH:0] c_LAST = (ADDR_WIDTH+1)'(depth(ADDR_WIDTH) - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic                  r_inflight;
    logic                  r_clear_done;
    logic [1:0]            w_buf_cnt;
    logic [1:0]            w_occ;
    logic                  w_req_fire;
    logic                  w_rd_fire;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_head;

    // Next-state selection; clear_start is only honoured while running.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:   if (clear_start)      w_state_next = ST_CLEAR;
            ST_CLEAR: if (r_cnt == c_LAST)  w_state_next = ST_RUN;
            default:                        w_state_next = ST_RUN;
        endcase
    end

    // State, clear counter, in-flight read flag and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= INIT_ON_RESET ? ST_CLEAR : ST_RUN;
            r_cnt        <= '0;
            r_inflight   <= 1'b0;
            r_clear_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_inflight   <= w_rd_fire;
            r_clear_done <= (r_state == ST_CLEAR) && (r_cnt == c_LAST);
            if (r_state == ST_CLEAR) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // Handshake and status; req_ready uses registered state only.
    always_comb begin
        w_occ      = {1'b0, r_inflight} + w_buf_cnt;
        req_ready  = !rst && (r_state == ST_RUN) && (w_occ < 2'd2);
        clear_busy = !rst && (r_state == ST_CLEAR);
        clear_done = !rst && r_clear_done;
        w_req_fire = req_valid && req_ready;
        w_rd_fire  = w_req_fire && !req_we;
    end

    // RAM port mux: clear writes take priority, else the accepted request.
    always_comb begin
        ram_ena   = 1'b0;
        ram_wea   = 1'b0;
        ram_addra = '0;
        ram_dina  = '0;
        if (clear_busy) begin
            ram_ena   = 1'b1;
            ram_wea   = 1'b1;
            ram_addra = r_cnt[ADDR_WIDTH-1:0];
            ram_dina  = INIT_VALUE;
        end else if (w_req_fire) begin
            ram_ena   = 1'b1;
            ram_wea   = req_we;
            ram_addra = req_addr;
            ram_dina  = req_wdata;
        end
    end

    // Response path: bypass douta when the buffer is empty, else serve the
    // buffer head and queue the arriving word behind it to keep order.
    always_comb begin
        w_push    = 1'b0;
        w_pop     = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = ram_douta;
        if (!rst) begin
            if (w_buf_cnt == 2'd0) begin
                rsp_valid = r_inflight;
                w_push    = r_inflight && !rsp_ready;
            end else begin
                rsp_valid = 1'b1;
                rsp_rdata = w_head;
                w_pop     = rsp_ready;
                w_push    = r_inflight;
            end
        end
    end

    sync_fifo2 #(
        .WIDTH (DATA_WIDTH)
    ) u_rsp_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (ram_douta),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_buf_cnt)
    );

endmodule
`default_nettype wire

// File: doc/sp_ram_ctrl.md
Name: sp_ram_ctrl

Overview:
- Initiator-side controller for the single-port RAM (`sp_ram`).
- Accepts read/write requests on a valid/ready channel and converts them to single-port RAM accesses: at most one access per cycle, never read and write together.
- Returns read data on a valid/ready response channel. The RAM's 1-cycle read latency and response backpressure are absorbed by a 2-entry buffer.
- Also provides a sequential clear engine that fills the whole memory with a constant.

Parameters:
- DATA_WIDTH, 32, data width; must match the RAM instance.
- ADDR_WIDTH, 10, address width; memory depth is 2**ADDR_WIDTH.
- INIT_VALUE, 0, DATA_WIDTH-bit value written by the clear engine.
- INIT_ON_RESET, 1, 1 = run a clear automatically after reset.

Ports:
- clk  in  1  clock (shared with RAM clka).
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  request address.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  read data valid.
- rsp_ready  in  1  response accepted.
- rsp_rdata  out  DATA_WIDTH  read data.
- clear_start  in  1  single-cycle pulse that starts a clear.
- clear_busy  out  1  clear in progress.
- clear_done  out  1  one-cycle pulse after the last clear write.
- ram_ena  out  1  to RAM ena.
- ram_wea  out  1  to RAM wea.
- ram_addra  out  ADDR_WIDTH  to RAM addra.
- ram_dina  out  DATA_WIDTH  to RAM dina.
- ram_douta  in  DATA_WIDTH  from RAM douta.

Behaviour:
- Reset behaviour:
  - Clock is clk; reset rst is synchronous and active-high.
  - While rst=1: req_ready=0, rsp_valid=0, clear_done=0, ram_ena=0, and the buffer and in-flight flag are cleared.
  - Leaving reset, state is CLEAR if INIT_ON_RESET=1, else RUN.
  - A reset mid-clear or mid-read discards all in-flight and buffered data.
- FSM states:
  - RUN: serves requests.
  - CLEAR: serves no requests.
- Transitions:
  - RUN -> CLEAR on clear_start=1.
  - CLEAR -> RUN in the cycle after the write to the last address (2**ADDR_WIDTH-1).
  - clear_start while in CLEAR is ignored.
- CLEAR operation:
  - clear_busy=1 and req_ready=0.
  - Every cycle: ram_ena=1, ram_wea=1, ram_addra=cnt, ram_dina=INIT_VALUE, with cnt counting 0 to 2**ADDR_WIDTH-1.
  - clear_done pulses for 1 cycle on entering RUN.
  - Outstanding read responses keep draining during CLEAR, because RAM writes do not disturb the registered douta.
- Occupancy:
  - occ = inflight (0/1) + buf_cnt (0..2).
  - req_ready = (state==RUN) & (occ < 2), computed from registered state only. It must not depend on req_valid, req_we or rsp_ready.
- Request handshake in RUN, when req_valid & req_ready in cycle N:
  - ram_ena=1, ram_wea=req_we, ram_addra=req_addr, ram_dina=req_wdata, all combinational in the same cycle N.
  - Otherwise ram_ena=0.
  - A write produces no response.
  - A read sets inflight=1 for cycle N+1.
- Response path:
  - In cycle N+1, ram_douta holds the read data.
  - If buf_cnt=0: rsp_valid=1 and rsp_rdata=ram_douta, a bypass with 1-cycle latency. If rsp_ready=0, ram_douta is pushed into the buffer.
  - If buf_cnt>0: the response is the buffer head, and the in-flight data is pushed to the tail.
  - Push and pop in the same cycle leave buf_cnt unchanged.
- Ordering and throughput:
  - Responses are returned strictly in request order.
  - With rsp_ready held at 1, back-to-back reads sustain 1 read/cycle.
  - Read-after-write to the same address returns the new data, because the RAM write completes before a subsequent read.
- Full buffer:
  - occ=2 forces req_ready=0; no read is ever issued without a free slot.
  - Buffer overflow is impossible by construction. The bench asserts this with a check that buf_cnt never exceeds 2.
- Address handling: the clear counter width is ADDR_WIDTH+1 so the end condition is detected without wrap.

Decomposition:
- Package `sp_ram_pkg`:
  - State encoding constants ST_RUN, ST_CLEAR.
  - Depth function 2**ADDR_WIDTH.
- One natural sub-module: `sync_fifo2`, a 2-entry synchronous FIFO with push/pop/count, used for the response buffer.
- Keep the FSM, occupancy logic and RAM muxing in `sp_ram_ctrl`.
- Benches instantiate `sp_ram_ctrl` together with `sp_ram` (DATA_WIDTH=32, ADDR_WIDTH=4 for short clears).

Test Plan:
- Auto-clear after reset:
  - Stimulus: INIT_ON_RESET=1, INIT_VALUE=32'hDEADBEEF, ADDR_WIDTH=4; release rst.
  - Required response: clear_busy=1 for exactly 16 cycles; clear_done pulses once; req_ready rises in the same cycle as clear_done. Reads of addr 0 and 15 both return 32'hDEADBEEF.
- Basic write then read:
  - Stimulus: write addr 3 = 32'h12345678; next cycle read addr 3; rsp_ready=1.
  - Required response: rsp_valid=1 one cycle after the read handshake, with rsp_rdata=32'h12345678.
- Streaming reads:
  - Stimulus: 8 back-to-back reads of addrs 0..7, preloaded with values 100+addr; rsp_ready=1.
  - Required response: req_ready stays 1 throughout; 8 consecutive responses 100..107 in order, no gaps.
- Backpressure:
  - Stimulus: rsp_ready=0; issue reads to addrs 1, 2, 3.
  - Required response: only 2 reads are accepted; req_ready=0 after the second. On raising rsp_ready, responses for addrs 1 then 2 arrive, then the third read is accepted.
- Clear with reads pending:
  - Stimulus: 2 buffered reads with rsp_ready=0, then clear_start.
  - Required response: the buffered responses hold their pre-clear data and drain correctly while clear_busy=1; a read issued after clear_done returns INIT_VALUE.
- Reset mid-clear:
  - Stimulus: assert rst at clear cycle 5 with INIT_ON_RESET=1.
  - Required response: rsp_valid=0 and req_ready=0 while rst=1. After release, the clear restarts at addr 0 and takes 16 full cycles.
